race_controller: RTL and testbench

//  Top-level race sequencer for two cars. Drives the shared 3-bit game state consumed by both PhysicsEngine instances
//  (state 4 = RACE = physics active); runs the 3-2-1 countdown, pause, per-player lap tracking from car positions,

---
 rtl/race_pkg.sv | 25 ++
 rtl/race_controller_if.sv | 24 ++
 rtl/lap_tracker.sv | 64 ++++++
 rtl/race_controller.sv | 160 ++++++++++++++++
 tb/tb_race_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/race_pkg.sv
// Shared race definitions: game-state encodings, winner codes, zone test.
package race_pkg;

  // PhysicsEngine compares the shared state against ST_RACE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd2,
    ST_RACE      = 3'd4,
    ST_FINISH    = 3'd5,
    ST_PAUSE     = 3'd6
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  // Inclusive, unsigned rectangle test in map pixels.
  function automatic logic in_zone(input logic [9:0] x, input logic [9:0] y,
                                   input logic [9:0] xl, input logic [9:0] xh,
                                   input logic [9:0] yl, input logic [9:0] yh);
    return (x >= xl) && (x <= xh) && (y >= yl) && (y <= yh);
  endfunction

endpackage

// File: rtl/race_controller_if.sv
// Button / car-position inputs and HUD/physics-facing outputs of the race sequencer.
interface race_controller_if;
  logic        start_btn;
  logic        pause_btn;
  logic [9:0]  p1_x, p1_y;
  logic [9:0]  p2_x, p2_y;
  logic [2:0]  state;
  logic        car_rst;
  logic [1:0]  countdown;
  logic [2:0]  p1_lap, p2_lap;
  logic [1:0]  winner;
  logic [15:0] race_time;
  logic        game_tick;

  modport master (
    output start_btn, pause_btn, p1_x, p1_y, p2_x, p2_y,
    input  state, car_rst, countdown, p1_lap, p2_lap, winner, race_time, game_tick
  );

  modport slave (
    input  start_btn, pause_btn, p1_x, p1_y, p2_x, p2_y,
    output state, car_rst, countdown, p1_lap, p2_lap, winner, race_time, game_tick
  );
endinterface

// File: rtl/lap_tracker.sv
// Per-car lap counter: the checkpoint arms, the finish line scores an armed car.
module lap_tracker
  import race_pkg::*;
#(
  parameter int         LAPS     = 3,
  parameter logic [9:0] FIN_X_LO = 10'd10,
  parameter logic [9:0] FIN_X_HI = 10'd30,
  parameter logic [9:0] FIN_Y_LO = 10'd100,
  parameter logic [9:0] FIN_Y_HI = 10'd140,
  parameter logic [9:0] CP_X_LO  = 10'd290,
  parameter logic [9:0] CP_X_HI  = 10'd310,
  parameter logic [9:0] CP_Y_LO  = 10'd100,
  parameter logic [9:0] CP_Y_HI  = 10'd140
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic [2:0] lap_o,
  output logic       done_o
);

  logic [2:0] lap_q, lap_d;
  logic       armed_q, armed_d;
  logic       in_fin, in_cp, hit;

  assign in_fin = in_zone(x_i, y_i, FIN_X_LO, FIN_X_HI, FIN_Y_LO, FIN_Y_HI);
  assign in_cp  = in_zone(x_i, y_i, CP_X_LO, CP_X_HI, CP_Y_LO, CP_Y_HI);
  // Finish crossing uses the armed bit from before this tick.
  assign hit    = en_i && in_fin && armed_q;
  // Strobes on the tick whose crossing completes the final lap.
  assign done_o = hit && (lap_q == 3'(LAPS - 1));
  assign lap_o  = lap_q;

  // Next lap/armed value: clear on a new race, else update on enabled ticks.
  always_comb begin
    lap_d   = lap_q;
    armed_d = armed_q;
    if (clear_i) begin
      lap_d   = '0;
      armed_d = 1'b0;
    end else if (en_i) begin
      if (hit) begin
        armed_d = 1'b0;
        if (lap_q != 3'(LAPS)) lap_d = lap_q + 3'd1;
      end
      if (in_cp) armed_d = 1'b1;
    end
  end

  // Lap and armed registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      lap_q   <= lap_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/race_controller.sv
// Race sequencer: game tick, button capture, countdown/race/pause FSM, timer and winner.
module race_controller
  import race_pkg::*;
#(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         LAPS     = 3,
  parameter int         CD_TICKS = 60,
  parameter logic [9:0] FIN_X_LO = 10'd10,
  parameter logic [9:0] FIN_X_HI = 10'd30,
  parameter logic [9:0] FIN_Y_LO = 10'd100,
  parameter logic [9:0] FIN_Y_HI = 10'd140,
  parameter logic [9:0] CP_X_LO  = 10'd290,
  parameter logic [9:0] CP_X_HI  = 10'd310,
  parameter logic [9:0] CP_Y_LO  = 10'd100,
  parameter logic [9:0] CP_Y_HI  = 10'd140
) (
  input  logic               clk,
  input  logic               rst,
  race_controller_if.slave   bus_io
);

  localparam int TICK_MAX = CLK_FREQ / 60;
  localparam int TW       = $clog2(TICK_MAX + 1);
  localparam int CW       = $clog2(CD_TICKS + 1);

  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic          start_pend_q, pause_pend_q, start_evt, pause_evt;
  state_e        state_q, state_d;
  logic [CW-1:0] cd_cnt_q, cd_cnt_d;
  logic [1:0]    countdown_q, countdown_d;
  logic [15:0]   race_time_q, race_time_d;
  logic [1:0]    winner_q, winner_d;
  logic          car_rst_q, car_rst_d;
  logic          lap_en, lap_clr;
  logic          done1, done2;
  logic [2:0]    lap1, lap2;

  assign tick = (tick_cnt_q == '0);

  // Free-running tick divider, reset with rst so it stays locked to the physics engines.
  always_ff @(posedge clk) begin
    if (rst)                            tick_cnt_q <= '0;
    else if (tick_cnt_q == TW'(TICK_MAX)) tick_cnt_q <= '0;
    else                                tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // A pulse landing on the tick edge itself is honoured directly.
  assign start_evt = start_pend_q | bus_io.start_btn;
  assign pause_evt = pause_pend_q | bus_io.pause_btn;

  // Sticky button flags, dropped on every tick whether used or not.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      start_pend_q <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      start_pend_q <= start_evt;
      pause_pend_q <= pause_evt;
    end
  end

  // Trackers run only on RACE ticks and are wiped when a new race starts.
  assign lap_en  = tick && (state_q == ST_RACE);
  assign lap_clr = tick && (state_q == ST_IDLE) && start_evt;

  lap_tracker #(
    .LAPS(LAPS),
    .FIN_X_LO(FIN_X_LO), .FIN_X_HI(FIN_X_HI), .FIN_Y_LO(FIN_Y_LO), .FIN_Y_HI(FIN_Y_HI),
    .CP_X_LO(CP_X_LO),   .CP_X_HI(CP_X_HI),   .CP_Y_LO(CP_Y_LO),   .CP_Y_HI(CP_Y_HI)
  ) u_lap1 (
    .clk(clk), .rst(rst), .clear_i(lap_clr), .en_i(lap_en),
    .x_i(bus_io.p1_x), .y_i(bus_io.p1_y), .lap_o(lap1), .done_o(done1)
  );

  lap_tracker #(
    .LAPS(LAPS),
    .FIN_X_LO(FIN_X_LO), .FIN_X_HI(FIN_X_HI), .FIN_Y_LO(FIN_Y_LO), .FIN_Y_HI(FIN_Y_HI),
    .CP_X_LO(CP_X_LO),   .CP_X_HI(CP_X_HI),   .CP_Y_LO(CP_Y_LO),   .CP_Y_HI(CP_Y_HI)
  ) u_lap2 (
    .clk(clk), .rst(rst), .clear_i(lap_clr), .en_i(lap_en),
    .x_i(bus_io.p2_x), .y_i(bus_io.p2_y), .lap_o(lap2), .done_o(done2)
  );

  // Next-state and registered outputs; everything moves only on tick edges.
  always_comb begin
    state_d     = state_q;
    cd_cnt_d    = cd_cnt_q;
    countdown_d = countdown_q;
    race_time_d = race_time_q;
    winner_d    = winner_q;
    car_rst_d   = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: if (start_evt) begin
          state_d     = ST_COUNTDOWN;
          car_rst_d   = 1'b1;
          winner_d    = WIN_NONE;
          race_time_d = '0;
          cd_cnt_d    = '0;
          countdown_d = 2'd3;
        end
        ST_COUNTDOWN: begin
          if (cd_cnt_q == CW'(CD_TICKS - 1)) begin
            cd_cnt_d    = '0;
            countdown_d = countdown_q - 2'd1;
            if (countdown_q == 2'd1) state_d = ST_RACE;
          end else begin
            cd_cnt_d = cd_cnt_q + CW'(1);
          end
        end
        ST_RACE: begin
          if (race_time_q != 16'hFFFF) race_time_d = race_time_q + 16'd1;
          // Finish beats a pending pause on the same tick.
          if (done1 || done2) begin
            state_d  = ST_FINISH;
            winner_d = {done2, done1};
          end else if (pause_evt) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_evt)      state_d = ST_RACE;
          else if (start_evt) state_d = ST_IDLE;
        end
        ST_FINISH: if (start_evt) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, timer and HUD registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cd_cnt_q    <= '0;
      countdown_q <= '0;
      race_time_q <= '0;
      winner_q    <= WIN_NONE;
      car_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_cnt_q    <= cd_cnt_d;
      countdown_q <= countdown_d;
      race_time_q <= race_time_d;
      winner_q    <= winner_d;
      car_rst_q   <= car_rst_d;
    end
  end

  assign bus_io.state     = state_q;
  assign bus_io.car_rst   = car_rst_q;
  assign bus_io.countdown = countdown_q;
  assign bus_io.p1_lap    = lap1;
  assign bus_io.p2_lap    = lap2;
  assign bus_io.winner    = winner_q;
  assign bus_io.race_time = race_time_q;
  assign bus_io.game_tick = tick;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller with a tick-level reference model.
module tb_race_controller;
  localparam int CLK_FREQ = 600;
  localparam int TMAX     = CLK_FREQ / 60;
  localparam int CD       = 2;
  localparam int LAPS     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  race_controller_if bus();

  race_controller #(.CLK_FREQ(CLK_FREQ), .LAPS(LAPS), .CD_TICKS(CD)) dut (
    .clk(clk), .rst(rst), .bus_io(bus)
  );

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  // Reference model state (values the outputs must show after each edge).
  int m_cnt, m_state, m_cd_left, m_win, m_rt;
  int m_lap[2];
  bit m_arm[2];
  bit m_crst, m_sp, m_pp;

  function automatic bit inz(int x, int y, int xl, int xh, int yl, int yh);
    return (x >= xl) && (x <= xh) && (y >= yl) && (y <= yh);
  endfunction

  // Model: one step per clock, race rules applied only on tick edges.
  always @(posedge clk) begin
    bit st, pp, tk, fin, cp;
    bit r[2];
    int px[2], py[2];
    m_crst = 1'b0;
    if (rst) begin
      m_cnt = 0; m_state = 0; m_cd_left = 0; m_win = 0; m_rt = 0;
      m_lap[0] = 0; m_lap[1] = 0; m_arm[0] = 0; m_arm[1] = 0;
      m_sp = 0; m_pp = 0;
    end else begin
      tk = (m_cnt == 0);
      m_cnt = (m_cnt == TMAX) ? 0 : m_cnt + 1;
      st = m_sp | bus.start_btn;
      pp = m_pp | bus.pause_btn;
      px[0] = bus.p1_x; py[0] = bus.p1_y; px[1] = bus.p2_x; py[1] = bus.p2_y;
      if (tk) begin
        m_sp = 0; m_pp = 0;
        case (m_state)
          0: if (st) begin
            m_state = 2; m_crst = 1; m_win = 0; m_rt = 0; m_cd_left = 3 * CD;
            m_lap[0] = 0; m_lap[1] = 0; m_arm[0] = 0; m_arm[1] = 0;
          end
          2: begin
            m_cd_left--;
            if (m_cd_left == 0) m_state = 4;
          end
          4: begin
            if (m_rt < 65535) m_rt++;
            for (int c = 0; c < 2; c++) begin
              r[c] = 0;
              fin = inz(px[c], py[c], 10, 30, 100, 140);
              cp  = inz(px[c], py[c], 290, 310, 100, 140);
              if (fin && m_arm[c]) begin
                m_arm[c] = 0;
                if (m_lap[c] < LAPS) begin
                  m_lap[c]++;
                  r[c] = (m_lap[c] == LAPS);
                end
              end
              if (cp) m_arm[c] = 1;
            end
            if (r[0] || r[1]) begin
              m_win = int'(r[0]) + 2 * int'(r[1]);
              m_state = 5;
            end else if (pp) m_state = 6;
          end
          6: if (pp) m_state = 4; else if (st) m_state = 0;
          5: if (st) m_state = 0;
          default: m_state = 0;
        endcase
      end else begin
        m_sp = st; m_pp = pp;
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance past n tick edges; lands on the negedge right after the last one.
  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      int b = 0;
      while (m_cnt != 0 && b < 20) begin @(negedge clk); b++; end
      if (b >= 20) cmp("tick_wait", b, 0);
      @(negedge clk);
    end
  endtask

  task automatic pulse(input bit s, input bit p);
    bus.start_btn = s; bus.pause_btn = p;
    @(negedge clk);
    bus.start_btn = 0; bus.pause_btn = 0;
  endtask

  task automatic pos(input int c, input int x, input int y);
    if (c == 1) begin bus.p1_x = 10'(x); bus.p1_y = 10'(y); end
    else        begin bus.p2_x = 10'(x); bus.p2_y = 10'(y); end
  endtask

  initial begin
    bus.start_btn = 0; bus.pause_btn = 0;
    pos(1, 500, 500); pos(2, 500, 500);
    fork
      begin : compare
        @(posedge clk);
        while (!done) begin
          @(negedge clk);
          cmp("m_state",     int'(bus.state),     m_state);
          cmp("m_car_rst",   int'(bus.car_rst),   int'(m_crst));
          cmp("m_countdown", int'(bus.countdown), (m_state == 2) ? (m_cd_left + CD - 1) / CD : 0);
          cmp("m_p1_lap",    int'(bus.p1_lap),    m_lap[0]);
          cmp("m_p2_lap",    int'(bus.p2_lap),    m_lap[1]);
          cmp("m_winner",    int'(bus.winner),    m_win);
          cmp("m_race_time", int'(bus.race_time), m_rt);
          cmp("m_game_tick", int'(bus.game_tick), int'(m_cnt == 0));
        end
      end
      begin : stim
        step(3);
        cmp("rst_state", int'(bus.state), 0);
        cmp("rst_countdown", int'(bus.countdown), 0);
        cmp("rst_race_time", int'(bus.race_time), 0);
        cmp("rst_game_tick", int'(bus.game_tick), 1);
        // 1: start -> COUNTDOWN on the first tick, one-clk car_rst
        rst = 0;
        pulse(1, 0);
        cmp("t1_state", int'(bus.state), 2);
        cmp("t1_car_rst", int'(bus.car_rst), 1);
        cmp("t1_countdown", int'(bus.countdown), 3);
        step(1);
        cmp("t1_car_rst_low", int'(bus.car_rst), 0);
        pulse(0, 1);  // pause ignored during countdown
        tk(6);
        cmp("t1_race", int'(bus.state), 4);
        cmp("t1_cd_zero", int'(bus.countdown), 0);
        // 2: P1 wins two laps
        pos(1, 300, 120); tk(1); pos(1, 20, 120); tk(1);
        cmp("t2_lap1", int'(bus.p1_lap), 1);
        pos(1, 300, 120); tk(1); pos(1, 20, 120); tk(1);
        cmp("t2_lap2", int'(bus.p1_lap), 2);
        cmp("t2_winner", int'(bus.winner), 1);
        cmp("t2_finish", int'(bus.state), 5);
        cmp("t2_time", int'(bus.race_time), 4);
        pos(1, 500, 500); tk(3);
        cmp("t2_time_frozen", int'(bus.race_time), 4);
        pulse(1, 0); tk(1);
        cmp("t2_idle", int'(bus.state), 0);
        cmp("t2_lap_kept", int'(bus.p1_lap), 2);
        pulse(1, 0); tk(1);
        cmp("t3_clr_lap", int'(bus.p1_lap), 0);
        cmp("t3_clr_win", int'(bus.winner), 0);
        cmp("t3_clr_time", int'(bus.race_time), 0);
        tk(6);
        // 3: unarmed finish, checkpoint boundary
        pos(1, 20, 120); tk(1);
        pos(1, 289, 120); tk(1);
        pos(1, 20, 120); tk(1);
        cmp("t3_no_arm", int'(bus.p1_lap), 0);
        pos(1, 290, 120); tk(1);
        pos(1, 20, 120); tk(1);
        cmp("t3_arm_edge", int'(bus.p1_lap), 1);
        // 5: pause freezes timer and laps
        pulse(0, 1); tk(1);
        cmp("t5_pause", int'(bus.state), 6);
        cmp("t5_time", int'(bus.race_time), 6);
        pos(1, 300, 120); tk(5); pos(1, 20, 120); tk(5);
        cmp("t5_time_frozen", int'(bus.race_time), 6);
        cmp("t5_lap_frozen", int'(bus.p1_lap), 1);
        pulse(0, 1); tk(1);
        cmp("t5_resume", int'(bus.state), 4);
        tk(2);
        cmp("t5_time_runs", int'(bus.race_time), 8);
        // 6: reset mid-race
        rst = 1; step(1);
        cmp("t6_state", int'(bus.state), 0);
        cmp("t6_lap", int'(bus.p1_lap), 0);
        cmp("t6_time", int'(bus.race_time), 0);
        cmp("t6_car_rst", int'(bus.car_rst), 0);
        rst = 0; step(1);
        pulse(1, 1); tk(1);
        cmp("t6_start_wins", int'(bus.state), 2);
        tk(6);
        cmp("t6_race", int'(bus.state), 4);
        // 4: simultaneous final lap -> tie
        pos(1, 300, 120); pos(2, 300, 120); tk(1);
        pos(1, 20, 120);  pos(2, 20, 120);  tk(1);
        pos(1, 300, 120); pos(2, 300, 120); tk(1);
        pos(1, 20, 120);  pos(2, 20, 120);  tk(1);
        cmp("t4_tie", int'(bus.winner), 3);
        cmp("t4_finish", int'(bus.state), 5);
        cmp("t4_p2_lap", int'(bus.p2_lap), 2);
        step(2);
        done = 1'b1;
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
